// File: rtl/memory_bus_master_if.sv
// Bus bundle for memory_bus_master: requester-side handshake plus the
// memory-side address/data/strobe lines. The master modport is the view
// of memory_bus_master; the slave modport is the view of everything
// attached to it (requester and memory device together).
interface memory_bus_master_if;
  logic        REQ;
  logic        REQ_WR;
  logic        REQ_BYTE;
  logic        REQ_LANE;
  logic [15:0] ADDR_IN;
  logic [15:0] WDATA;
  logic [15:0] RDATA;
  logic        BUSY;
  logic        DONE;
  logic        ERR;
  logic [15:0] ADDR;
  logic [15:0] DOUT;
  logic [15:0] DIN;
  logic        RDN;
  logic        WR0N;
  logic        WR1N;

  modport master (
    input  REQ, REQ_WR, REQ_BYTE, REQ_LANE, ADDR_IN, WDATA, DIN,
    output RDATA, BUSY, DONE, ERR, ADDR, DOUT, RDN, WR0N, WR1N
  );

  modport slave (
    output REQ, REQ_WR, REQ_BYTE, REQ_LANE, ADDR_IN, WDATA, DIN,
    input  RDATA, BUSY, DONE, ERR, ADDR, DOUT, RDN, WR0N, WR1N
  );
endinterface

// File: rtl/memory_bus_master.sv
// memory_bus_master: single-access asynchronous-SRAM style bus master.
// Each accepted request runs SETUP (address/data valid, strobes high),
// STROBE (WAIT_CYCLES+1 cycles of active-low strobe) and HOLD (strobes
// high, DONE pulse), then returns to IDLE. All outputs are registered.
// Optional feature: define MEMBUS_ROM_PROTECT_EN to suppress the write
// strobes of any write below ROM_TOP and flag it with ERR alongside DONE.
module memory_bus_master #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [15:0] ROM_TOP     = 16'h2000
) (
  input logic                 CLK,
  input logic                 RESET,
  memory_bus_master_if.master bus
);

`ifdef MEMBUS_ROM_PROTECT_EN
  localparam logic PROTECT_EN = 1'b1;
`else
  localparam logic PROTECT_EN = 1'b0;
`endif

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_STROBE = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  // Counter load value: counts the STROBE cycles remaining after the current one.
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] dout_q, dout_d;
  logic [15:0] rdata_q, rdata_d;
  logic        wr_q, wr_d;
  logic        byte_q, byte_d;
  logic        lane_q, lane_d;
  logic        prot_q, prot_d;
  logic        rdn_q, rdn_d;
  logic        wr0n_q, wr0n_d;
  logic        wr1n_q, wr1n_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        prot_s;

  // Decide at acceptance whether this write targets protected ROM space.
  always_comb begin
    prot_s = PROTECT_EN && bus.REQ_WR && (bus.ADDR_IN < ROM_TOP);
  end

  // Next-state and next-output logic for the access sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    rdata_d = rdata_q;
    wr_d    = wr_q;
    byte_d  = byte_q;
    lane_d  = lane_q;
    prot_d  = prot_q;
    rdn_d   = rdn_q;
    wr0n_d  = wr0n_q;
    wr1n_d  = wr1n_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.REQ) begin
          state_d = ST_SETUP;
          addr_d  = bus.ADDR_IN;
          // A byte write replicates the byte on both lanes so either strobe sees it.
          dout_d  = bus.REQ_BYTE ? {bus.WDATA[7:0], bus.WDATA[7:0]} : bus.WDATA;
          wr_d    = bus.REQ_WR;
          byte_d  = bus.REQ_BYTE;
          lane_d  = bus.REQ_LANE;
          prot_d  = prot_s;
          busy_d  = 1'b1;
        end else begin
          busy_d  = 1'b0;
        end
      end
      ST_SETUP: begin
        state_d = ST_STROBE;
        cnt_d   = WAIT_LOAD;
        rdn_d   = wr_q;
        wr0n_d  = ~(wr_q & ~prot_q & (~byte_q | ~lane_q));
        wr1n_d  = ~(wr_q & ~prot_q & (~byte_q |  lane_q));
      end
      ST_STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_HOLD;
          rdn_d   = 1'b1;
          wr0n_d  = 1'b1;
          wr1n_d  = 1'b1;
          done_d  = 1'b1;
          err_d   = prot_q;
          if (!wr_q) begin
            if (byte_q) begin
              rdata_d = lane_q ? {8'h00, bus.DIN[15:8]} : {8'h00, bus.DIN[7:0]};
            end else begin
              rdata_d = bus.DIN;
            end
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_HOLD: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        rdn_d   = 1'b1;
        wr0n_d  = 1'b1;
        wr1n_d  = 1'b1;
      end
    endcase
  end

  // State and output registers; reset drives the bus to its safe idle levels at once.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 16'h0000;
      dout_q  <= 16'h0000;
      rdata_q <= 16'h0000;
      wr_q    <= 1'b0;
      byte_q  <= 1'b0;
      lane_q  <= 1'b0;
      prot_q  <= 1'b0;
      rdn_q   <= 1'b1;
      wr0n_q  <= 1'b1;
      wr1n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
      byte_q  <= byte_d;
      lane_q  <= lane_d;
      prot_q  <= prot_d;
      rdn_q   <= rdn_d;
      wr0n_q  <= wr0n_d;
      wr1n_q  <= wr1n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.RDATA = rdata_q;
  assign bus.BUSY  = busy_q;
  assign bus.DONE  = done_q;
  assign bus.ERR   = err_q;
  assign bus.ADDR  = addr_q;
  assign bus.DOUT  = dout_q;
  assign bus.RDN   = rdn_q;
  assign bus.WR0N  = wr0n_q;
  assign bus.WR1N  = wr1n_q;

endmodule

// File: tb/tb_memory_bus_master.sv
// Testbench for memory_bus_master: directed scenarios followed by random
// accesses, every cycle of every access compared against a cycle-index
// timing model and a word-array reference memory.
module tb_memory_bus_master;
  localparam int W = 1;

  logic CLK = 1'b0;
  logic RESET;
  int   vectors = 0;
  int   miscompares = 0;
  logic [15:0] exp_rdata;

  memory_bus_master_if bus ();

  memory_bus_master #(.WAIT_CYCLES(W), .ROM_TOP(16'h2000)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // Memory device on the bus and the reference model's independent copy.
  logic [15:0] mem     [0:65535] = '{default: 16'h1000};
  logic [15:0] ref_mem [0:65535] = '{default: 16'h1000};

  assign bus.DIN = mem[bus.ADDR];

  // Memory device: byte lanes written on any clock edge seeing their strobe low.
  always @(posedge CLK) begin
    if (!bus.WR0N) mem[bus.ADDR][7:0]  <= bus.DOUT[7:0];
    if (!bus.WR1N) mem[bus.ADDR][15:8] <= bus.DOUT[15:8];
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One access from acceptance through the first IDLE cycle. Call at
  // posedge+1 with the master idle. With noisy set, request inputs are
  // scrambled while busy to show they are neither sampled nor re-latched.
  task automatic do_access(input bit wr, input bit bt, input bit lane,
                           input logic [15:0] a, input logic [15:0] wd, input bit noisy);
    bit prot, e0, e1, sw;
    logic [15:0] exp_dout, rw, rd_exp;
    prot = 1'b0;
`ifdef MEMBUS_ROM_PROTECT_EN
    prot = wr && (a < 16'h2000);
`endif
    exp_dout = bt ? {wd[7:0], wd[7:0]} : wd;
    e0 = wr && !prot && (!bt || !lane);
    e1 = wr && !prot && (!bt ||  lane);
    rw = ref_mem[a];
    rd_exp = bt ? (lane ? {8'h00, rw[15:8]} : {8'h00, rw[7:0]}) : rw;

    bus.REQ = 1'b1; bus.REQ_WR = wr; bus.REQ_BYTE = bt; bus.REQ_LANE = lane;
    bus.ADDR_IN = a; bus.WDATA = wd;
    @(posedge CLK); #1;
    bus.REQ = 1'b0;
    for (int k = 0; k <= W + 3; k++) begin
      sw = (k >= 1) && (k <= W + 1);
      if (k == W + 2 && !wr) exp_rdata = rd_exp;
      check_eq("busy", 16'(bus.BUSY), 16'(k <= W + 2));
      check_eq("done", 16'(bus.DONE), 16'(k == W + 2));
      check_eq("err",  16'(bus.ERR),  16'((k == W + 2) && prot));
      check_eq("rdn",  16'(bus.RDN),  16'(!(sw && !wr)));
      check_eq("wr0n", 16'(bus.WR0N), 16'(!(sw && e0)));
      check_eq("wr1n", 16'(bus.WR1N), 16'(!(sw && e1)));
      check_eq("rdata", bus.RDATA, exp_rdata);
      if (k <= W + 2) begin
        check_eq("addr", bus.ADDR, a);
        if (wr) check_eq("dout", bus.DOUT, exp_dout);
      end
      if (noisy && k <= W + 2) begin
        bus.REQ = 1'($urandom); bus.REQ_WR = 1'($urandom); bus.REQ_BYTE = 1'($urandom);
        bus.REQ_LANE = 1'($urandom); bus.ADDR_IN = 16'($urandom); bus.WDATA = 16'($urandom);
      end
      if (k == W + 3) bus.REQ = 1'b0;
      else begin
        @(posedge CLK); #1;
      end
    end
    if (e0) ref_mem[a][7:0]  = exp_dout[7:0];
    if (e1) ref_mem[a][15:8] = exp_dout[15:8];
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_rdn"},   16'(bus.RDN),  16'd1);
    check_eq({tag, "_wr0n"},  16'(bus.WR0N), 16'd1);
    check_eq({tag, "_wr1n"},  16'(bus.WR1N), 16'd1);
    check_eq({tag, "_busy"},  16'(bus.BUSY), 16'd0);
    check_eq({tag, "_done"},  16'(bus.DONE), 16'd0);
    check_eq({tag, "_err"},   16'(bus.ERR),  16'd0);
    check_eq({tag, "_addr"},  bus.ADDR,  16'h0000);
    check_eq({tag, "_dout"},  bus.DOUT,  16'h0000);
    check_eq({tag, "_rdata"}, bus.RDATA, 16'h0000);
  endtask

  // Reset asserted mid-cycle in cycle 1 of a word write: the access must abort.
  task automatic reset_abort(input logic [15:0] a, input logic [15:0] wd);
    bus.REQ = 1'b1; bus.REQ_WR = 1'b1; bus.REQ_BYTE = 1'b0; bus.REQ_LANE = 1'b0;
    bus.ADDR_IN = a; bus.WDATA = wd;
    @(posedge CLK); #1;
    bus.REQ = 1'b0;
    @(posedge CLK); #1;
    check_eq("abort_wr0n_low", 16'(bus.WR0N), 16'd0);
    check_eq("abort_wr1n_low", 16'(bus.WR1N), 16'd0);
    #1 RESET = 1'b1;
    #1;
    check_reset_state("abort");
    exp_rdata = 16'h0000;
    @(posedge CLK); #1;
    RESET = 1'b0;
    for (int i = 0; i < W + 3; i++) begin
      @(posedge CLK); #1;
      check_eq("abort_no_done", 16'(bus.DONE), 16'd0);
      check_eq("abort_idle",    16'(bus.BUSY), 16'd0);
    end
  endtask

  initial begin
    logic [15:0] pool [6];
    pool[0] = 16'h0000; pool[1] = 16'h0001; pool[2] = 16'h1fff;
    pool[3] = 16'h2000; pool[4] = 16'h3000; pool[5] = 16'hffff;
    exp_rdata = 16'h0000;
    RESET = 1'b1;
    bus.REQ = 1'b1; bus.REQ_WR = 1'b0; bus.REQ_BYTE = 1'b0; bus.REQ_LANE = 1'b0;
    bus.ADDR_IN = 16'h1234; bus.WDATA = 16'h5678;
    #3;
    check_reset_state("reset");
    repeat (2) @(posedge CLK);
    #1;
    check_reset_state("reset_held");
    RESET = 1'b0;

    // Word read of unwritten location 0: first edge after release accepts it.
    do_access(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    check_eq("rd0_value", bus.RDATA, 16'h1000);

    do_access(1'b1, 1'b0, 1'b0, 16'h2000, 16'habcd, 1'b0);
    do_access(1'b0, 1'b0, 1'b0, 16'h2000, 16'h0000, 1'b0);
    check_eq("wr_rd_2000", bus.RDATA, 16'habcd);

    do_access(1'b1, 1'b0, 1'b0, 16'h3000, 16'hdcba, 1'b0);
    do_access(1'b1, 1'b1, 1'b0, 16'h3000, 16'h00ee, 1'b0);
    do_access(1'b0, 1'b0, 1'b0, 16'h3000, 16'h0000, 1'b0);
    check_eq("byte_lane0", bus.RDATA, 16'hdcee);

    do_access(1'b1, 1'b0, 1'b0, 16'h3000, 16'hdcba, 1'b0);
    do_access(1'b1, 1'b1, 1'b1, 16'h3000, 16'h00ee, 1'b0);
    do_access(1'b0, 1'b1, 1'b1, 16'h3000, 16'h0000, 1'b0);
    check_eq("byte_rd_lane1", bus.RDATA, 16'h00ee);
    do_access(1'b0, 1'b0, 1'b0, 16'h3000, 16'h0000, 1'b0);
    check_eq("byte_lane1", bus.RDATA, 16'heeba);

    do_access(1'b1, 1'b0, 1'b0, 16'h0000, 16'habcd, 1'b0);
    do_access(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
`ifdef MEMBUS_ROM_PROTECT_EN
    check_eq("rom_protect", bus.RDATA, 16'h1000);
`else
    check_eq("rom_open", bus.RDATA, 16'habcd);
`endif

    reset_abort(16'h3000, 16'h5a5a);
    do_access(1'b0, 1'b0, 1'b0, 16'h3000, 16'h0000, 1'b0);
    check_eq("after_abort", bus.RDATA, 16'heeba);

    // Random accesses, back-to-back or with short idle gaps.
    for (int n = 0; n < 80; n++) begin
      do_access(1'($urandom), 1'($urandom), 1'($urandom),
                pool[$urandom_range(0, 5)], 16'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        @(posedge CLK); #1;
        check_eq("gap_idle", 16'(bus.BUSY), 16'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/memory_bus_master.md
MEMORY_BUS_MASTER -- requirements
Module: memory_bus_master

Interface
REQ-001 Parameter: WAIT_CYCLES, 1, extra strobe-low cycles per access (legal 0..15).
REQ-002 Parameter: ROM_TOP, 16'h2000, first writable address when ROM protection is compiled in.
REQ-003 Reset and clock: one clock CLK; RESET is asynchronous and active-high.
REQ-004 Port: CLK  in  1  system clock; all state changes on its rising edge.
REQ-005 Port: RESET  in  1  asynchronous active-high reset.
REQ-006 Port: REQ  in  1  access request; level signal, sampled only in IDLE.
REQ-007 Port: REQ_WR  in  1  1 = write, 0 = read.
REQ-008 Port: REQ_BYTE  in  1  1 = byte access, 0 = word access.
REQ-009 Port: REQ_LANE  in  1  byte lane for byte access: 0 = low byte, 1 = high byte.
REQ-010 Port: ADDR_IN  in  16  request address.
REQ-011 Port: WDATA  in  16  write data; a byte write uses WDATA[7:0].
REQ-012 Port: RDATA  out  16  read result.
REQ-013 Port: BUSY  out  1  high in every state except IDLE.
REQ-014 Port: DONE  out  1  one-cycle completion pulse.
REQ-015 Port: ERR  out  1  one-cycle pulse, coincident with DONE, for a suppressed write.
REQ-016 Port: ADDR  out  16  memory address.
REQ-017 Port: DOUT  out  16  memory write data; connects to the memory DIN.
REQ-018 Port: DIN  in  16  memory read data; connects to the memory DOUT.
REQ-019 Port: RDN, WR0N, WR1N  out  1 each  active-low read strobe, low-byte write strobe and high-byte write strobe.

Function
REQ-020 The FSM has four states: IDLE, SETUP, STROBE and HOLD.
REQ-021 Acceptance: a rising edge with state IDLE and REQ=1 latches ADDR_IN, WDATA and the operation fields, then moves to SETUP.
REQ-022 Cycle numbering: cycle 0 is the cycle after the acceptance edge, and is SETUP. ADDR and DOUT are valid from cycle 0 and all strobes are high in SETUP.
REQ-023 STROBE occupies cycles 1..WAIT_CYCLES+1 and uses a 4-bit down-counter. During STROBE, ADDR and DOUT are held stable.
REQ-024 HOLD is cycle WAIT_CYCLES+2: strobes high, ADDR held, DONE=1. The FSM returns to IDLE at the next edge.
REQ-025 Strobe selection in STROBE:
- Read: RDN=0.
- Word write: WR0N=0 and WR1N=0.
- Byte write: only WR0N (lane 0) or only WR1N (lane 1) is low.
REQ-026 RDN and any WRxN are never low in the same cycle. All strobes are high outside STROBE.
REQ-027 Byte-write data: DOUT = {WDATA[7:0], WDATA[7:0]}. Word-write data: DOUT = WDATA.
REQ-028 Read capture: DIN is captured at the edge ending the last STROBE cycle.
- Word read: RDATA = DIN.
- Byte read: RDATA = {8'h00, selected lane}.
REQ-029 RDATA changes only on read completion; writes leave it unchanged.
REQ-030 REQ while BUSY=1 is ignored. REQ still high in the first IDLE cycle after HOLD starts a new access, so the minimum access period is WAIT_CYCLES+4 cycles.
REQ-031 With WAIT_CYCLES=0 the strobe is low for exactly one cycle.

Reset
REQ-032 Asserting RESET forces the following immediately, without waiting for a clock:
- state = IDLE;
- RDN = WR0N = WR1N = 1;
- ADDR = 0, DOUT = 0, RDATA = 0;
- BUSY = DONE = ERR = 0.
REQ-033 Reset during STROBE aborts the access: strobes rise asynchronously, no DONE is produced, and RDATA is 0.
REQ-034 The first access after release is accepted at the first rising edge with RESET=0 and REQ=1.

Configuration
REQ-035 Macro MEMBUS_ROM_PROTECT_EN defined: a write with latched address < ROM_TOP runs the full SETUP/STROBE/HOLD timing, but WR0N and WR1N stay high, and ERR=1 together with DONE.
REQ-036 MEMBUS_ROM_PROTECT_EN undefined: all writes drive their strobes, and ERR is tied to 0.

Verification
REQ-037 WAIT_CYCLES=1, word read of 16'h0000, memory model returns 16'h1000:
- RDN low in cycles 1-2;
- DONE in cycle 3;
- RDATA=16'h1000;
- BUSY low from cycle 4.
REQ-038 Word write of 16'habcd to 16'h2000, then word read of 16'h2000:
- WR0N and WR1N low together for WAIT_CYCLES+1 cycles;
- read returns 16'habcd.
REQ-039 Word write of 16'hdcba to 16'h3000, then byte write lane 0 with WDATA=16'h00ee, then word read:
- DOUT=16'heeee during the byte write;
- only WR0N low;
- read returns 16'hdcee.
REQ-040 Word write of 16'hdcba, then byte write lane 1 with WDATA=16'h00ee, then byte read lane 1 of 16'h3000:
- RDATA=16'h00ee;
- a following word read returns 16'heeba.
REQ-041 With MEMBUS_ROM_PROTECT_EN defined, word write of 16'habcd to 16'h0000:
- WR0N and WR1N stay high;
- DONE and ERR pulse together;
- a following read returns 16'h1000.
REQ-042 RESET asserted in cycle 1 of a write:
- WR0N and WR1N rise within the same cycle;
- BUSY=0 and no DONE;
- the next REQ completes normally.
